// File: rtl/feature_fetch_pkg.sv
// Shared definitions for the fetch sequencers: state encoding, default widths and fetch types.
// Imported by the feature-fetch sequencer today and by the weight-fetch sequencer later.
package feature_fetch_pkg;

   localparam int unsigned SRC_W_DEF   = 16;
   localparam int unsigned DST_W_DEF   = 8;
   localparam int unsigned LEN_W_DEF   = 8;
   localparam int unsigned TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } fetch_state_e;

   localparam logic [7:0] FETCH_TYPE_FEATURE = 8'h01;
   localparam logic [7:0] FETCH_TYPE_WEIGHT  = 8'h02;
   localparam logic [7:0] FETCH_TYPE_BIAS    = 8'h03;

endpackage

// File: rtl/feature_fetch_sequencer_if.sv
// Command and fetch-unit signals of the feature-fetch sequencer.
// master = top FSM plus fetch unit side, slave = the sequencer itself.
interface feature_fetch_sequencer_if #(
   parameter int unsigned SRC_W = 16,
   parameter int unsigned DST_W = 8,
   parameter int unsigned LEN_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [SRC_W-1:0] cmd_src_addr;
   logic [7:0]       cmd_src_stride;
   logic [DST_W-1:0] cmd_dst_addr;
   logic [LEN_W-1:0] cmd_len;
   logic [7:0]       cmd_type;
   logic [7:0]       cmd_mem_sel;
   logic             fetch_enable;
   logic [SRC_W-1:0] fetch_src_addr;
   logic [DST_W-1:0] fetch_dst_addr;
   logic [7:0]       fetch_type;
   logic [7:0]       fetch_mem_sel;
   logic             fetch_done;
   logic             seq_busy;
   logic             seq_done;
   logic             seq_err;
   logic [LEN_W-1:0] lines_done;

   modport master (
      output cmd_valid, cmd_src_addr, cmd_src_stride, cmd_dst_addr, cmd_len, cmd_type,
             cmd_mem_sel, fetch_done,
      input  cmd_ready, fetch_enable, fetch_src_addr, fetch_dst_addr, fetch_type, fetch_mem_sel,
             seq_busy, seq_done, seq_err, lines_done
   );

   modport slave (
      input  cmd_valid, cmd_src_addr, cmd_src_stride, cmd_dst_addr, cmd_len, cmd_type,
             cmd_mem_sel, fetch_done,
      output cmd_ready, fetch_enable, fetch_src_addr, fetch_dst_addr, fetch_type, fetch_mem_sel,
             seq_busy, seq_done, seq_err, lines_done
   );

endinterface

// File: rtl/fetch_watchdog.sv
// Clearable up-counter; tc_o flags the TIMEOUT-th consecutive enabled cycle since the last clear.
module fetch_watchdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int unsigned CntW = $clog2(TIMEOUT);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter holds enabled cycles already elapsed, so the current one is number cnt_q + 1.
   assign tc_o = en_i && (cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/feature_fetch_sequencer.sv
// Expands one multi-line fetch command into per-line fetch requests, waiting for each fetch_done
// and aborting with a sticky error when a line times out.
module feature_fetch_sequencer
   import feature_fetch_pkg::*;
#(
   parameter int unsigned SRC_W   = SRC_W_DEF,
   parameter int unsigned DST_W   = DST_W_DEF,
   parameter int unsigned LEN_W   = LEN_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input logic                      clk,
   input logic                      rst,
   feature_fetch_sequencer_if.slave bus
);
   fetch_state_e     state_q, state_d;
   logic [SRC_W-1:0] src_q, src_d;
   logic [DST_W-1:0] dst_q, dst_d;
   logic [7:0]       stride_q, stride_d;
   logic [7:0]       type_q, type_d;
   logic [7:0]       mem_q, mem_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [LEN_W-1:0] lines_q, lines_d;
   logic             en_q, en_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             wd_clr, wd_en, wd_tc;

   assign wd_clr = (state_q == StIssue);
   assign wd_en  = (state_q == StWait);

   fetch_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk  (clk),
      .rst  (rst),
      .clr_i(wd_clr),
      .en_i (wd_en),
      .tc_o (wd_tc)
   );

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      stride_d = stride_q;
      type_d   = type_q;
      mem_d    = mem_q;
      rem_d    = rem_q;
      lines_d  = lines_q;
      err_d    = err_q;
      en_d     = 1'b0;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               src_d    = bus.cmd_src_addr;
               dst_d    = bus.cmd_dst_addr;
               stride_d = bus.cmd_src_stride;
               type_d   = bus.cmd_type;
               mem_d    = bus.cmd_mem_sel;
               rem_d    = bus.cmd_len;
               lines_d  = '0;
               err_d    = 1'b0;
               if (bus.cmd_len == '0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StIssue;
                  en_d    = 1'b1;
               end
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            // A completion in the same cycle as the timeout still counts.
            if (bus.fetch_done) begin
               lines_d = lines_q + LEN_W'(1);
               rem_d   = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  src_d   = src_q + SRC_W'(stride_q);
                  dst_d   = dst_q + DST_W'(1);
                  state_d = StIssue;
                  en_d    = 1'b1;
               end
            end else if (wd_tc) begin
               err_d   = 1'b1;
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         src_q    <= '0;
         dst_q    <= '0;
         stride_q <= '0;
         type_q   <= '0;
         mem_q    <= '0;
         rem_q    <= '0;
         lines_q  <= '0;
         en_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         stride_q <= stride_d;
         type_q   <= type_d;
         mem_q    <= mem_d;
         rem_q    <= rem_d;
         lines_q  <= lines_d;
         en_q     <= en_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.cmd_ready      = (state_q == StIdle);
   assign bus.seq_busy       = (state_q != StIdle);
   assign bus.fetch_enable   = en_q;
   assign bus.fetch_src_addr = src_q;
   assign bus.fetch_dst_addr = dst_q;
   assign bus.fetch_type     = type_q;
   assign bus.fetch_mem_sel  = mem_q;
   assign bus.seq_done       = done_q;
   assign bus.seq_err        = err_q;
   assign bus.lines_done     = lines_q;

endmodule

// File: tb/tb_feature_fetch_sequencer.sv
// Scoreboard bench: commands push expected fetch requests and completions; a monitor pops them.
// The fetch-unit model answers each request 3 cycles later unless told to drop it.
module tb_feature_fetch_sequencer;
   localparam int TIMEOUT = 15;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_errs;
   int   drop_cyc;
   int   spur_cyc;
   bit   in_rst;

   typedef struct {int cyc; int src; int dst; int typ; int mem;} en_t;
   typedef struct {int cyc; int lines; int err; bit len0;} dn_t;
   en_t exp_en[$];
   dn_t exp_dn[$];
   int  pend[$];
   en_t e_mon;
   dn_t d_mon;

   int last_lines, last_err, last_typ, last_mem;

   feature_fetch_sequencer_if #(.SRC_W(16), .DST_W(8), .LEN_W(8)) bus ();

   feature_fetch_sequencer #(
      .SRC_W  (16),
      .DST_W  (8),
      .LEN_W  (8),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Fetch-unit model
   initial begin
      logic fd;
      forever begin
         @(negedge clk);
         if (bus.fetch_enable && cyc != drop_cyc) pend.push_back(cyc + 3);
         fd = 1'b0;
         while (pend.size() > 0 && pend[0] <= cyc) begin
            if (pend[0] == cyc) fd = 1'b1;
            void'(pend.pop_front());
         end
         if (cyc == spur_cyc) fd = 1'b1;
         bus.fetch_done = fd;
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!in_rst) begin
            if (bus.fetch_enable) begin
               if (exp_en.size() == 0) begin
                  chk("unexpected_fetch_enable", 1, 0);
               end else begin
                  e_mon = exp_en.pop_front();
                  chk("fetch_enable_cycle", cyc, e_mon.cyc);
                  chk("fetch_src_addr", int'(bus.fetch_src_addr), e_mon.src);
                  chk("fetch_dst_addr", int'(bus.fetch_dst_addr), e_mon.dst);
                  chk("fetch_type", int'(bus.fetch_type), e_mon.typ);
                  chk("fetch_mem_sel", int'(bus.fetch_mem_sel), e_mon.mem);
               end
            end
            if (bus.seq_done) begin
               if (exp_dn.size() == 0) begin
                  chk("unexpected_seq_done", 1, 0);
               end else begin
                  d_mon = exp_dn.pop_front();
                  if (d_mon.len0)
                     chk("seq_done_cycle_len0_in_window",
                         int'(cyc >= d_mon.cyc && cyc <= d_mon.cyc + 1), 1);
                  else
                     chk("seq_done_cycle", cyc, d_mon.cyc);
                  chk("lines_done", int'(bus.lines_done), d_mon.lines);
                  chk("seq_err", int'(bus.seq_err), d_mon.err);
               end
            end
         end
      end
   end

   // Reference model: expected requests and completion from the command's arithmetic rules.
   task automatic push_expect(input int c, input logic [15:0] src, input logic [7:0] stride,
                              input logic [7:0] dst, input int len, input logic [7:0] typ,
                              input logic [7:0] mem, input int drop);
      int          issued;
      logic [15:0] s;
      logic [7:0]  d;
      dn_t         dn;
      issued = (drop >= 0) ? drop + 1 : len;
      for (int i = 0; i < issued; i++) begin
         s = src + 16'(i) * 16'(stride);
         d = dst + 8'(i);
         exp_en.push_back('{c + 1 + 4 * i, int'(s), int'(d), int'(typ), int'(mem)});
      end
      if (drop >= 0) begin
         dn = '{c + 1 + 4 * drop + TIMEOUT + 1, drop, 1, 1'b0};
         drop_cyc = c + 1 + 4 * drop;
      end else begin
         dn = '{(len == 0) ? c + 1 : c + 4 * len + 1, len, 0, len == 0};
         drop_cyc = -1;
      end
      exp_dn.push_back(dn);
      last_lines = dn.lines;
      last_err   = dn.err;
      last_typ   = int'(typ);
      last_mem   = int'(mem);
   endtask

   task automatic drive_cmd(input logic [15:0] src, input logic [7:0] stride,
                            input logic [7:0] dst, input int len, input logic [7:0] typ,
                            input logic [7:0] mem);
      bus.cmd_valid      = 1'b1;
      bus.cmd_src_addr   = src;
      bus.cmd_src_stride = stride;
      bus.cmd_dst_addr   = dst;
      bus.cmd_len        = 8'(len);
      bus.cmd_type       = typ;
      bus.cmd_mem_sel    = mem;
   endtask

   task automatic scramble();
      bus.cmd_src_addr   = 16'($urandom);
      bus.cmd_src_stride = 8'($urandom);
      bus.cmd_dst_addr   = 8'($urandom);
      bus.cmd_len        = 8'($urandom);
      bus.cmd_type       = 8'($urandom);
      bus.cmd_mem_sel    = 8'($urandom);
   endtask

   // Called just after a negedge with the sequencer idle.
   task automatic send(input logic [15:0] src, input logic [7:0] stride, input logic [7:0] dst,
                       input int len, input logic [7:0] typ, input logic [7:0] mem,
                       input int drop);
      chk("cmd_ready_before_accept", int'(bus.cmd_ready), 1);
      drive_cmd(src, stride, dst, len, typ, mem);
      push_expect(cyc, src, stride, dst, len, typ, mem, drop);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      scramble();
      chk("seq_err_cleared_on_accept", int'(bus.seq_err), 0);
      chk("lines_done_cleared_on_accept", int'(bus.lines_done), 0);
   endtask

   task automatic wait_quiet();
      int k;
      k = 0;
      while ((exp_en.size() != 0 || exp_dn.size() != 0) && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) begin
         n_checks++;
         n_errs++;
         $display("FAIL drain_timeout: %0d requests and %0d completions still outstanding",
                  exp_en.size(), exp_dn.size());
         exp_en.delete();
         exp_dn.delete();
      end
      @(negedge clk);
      chk("idle_cmd_ready", int'(bus.cmd_ready), 1);
      chk("idle_seq_busy", int'(bus.seq_busy), 0);
      chk("idle_fetch_enable", int'(bus.fetch_enable), 0);
      chk("idle_lines_done_hold", int'(bus.lines_done), last_lines);
      chk("idle_seq_err_hold", int'(bus.seq_err), last_err);
      chk("idle_fetch_type_hold", int'(bus.fetch_type), last_typ);
      chk("idle_fetch_mem_sel_hold", int'(bus.fetch_mem_sel), last_mem);
   endtask

   initial begin
      int c, c2, len, drop;
      logic [15:0] s;
      logic [7:0]  st, d, t, m;
      n_checks  = 0;
      n_errs    = 0;
      drop_cyc  = -1;
      spur_cyc  = -1;
      in_rst    = 1'b1;
      rst       = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.fetch_done = 1'b0;
      scramble();
      last_lines = 0;
      last_err   = 0;
      last_typ   = 0;
      last_mem   = 0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
      chk("rst_fetch_enable", int'(bus.fetch_enable), 0);
      chk("rst_seq_busy", int'(bus.seq_busy), 0);
      chk("rst_seq_done", int'(bus.seq_done), 0);
      chk("rst_seq_err", int'(bus.seq_err), 0);
      chk("rst_lines_done", int'(bus.lines_done), 0);
      chk("rst_fetch_src", int'(bus.fetch_src_addr), 0);
      chk("rst_fetch_type", int'(bus.fetch_type), 0);
      rst    = 1'b0;
      in_rst = 1'b0;
      @(negedge clk);

      // Three-line command, then no-op, then address wrap
      send(16'h0100, 8'd2, 8'h10, 3, 8'h01, 8'h00, -1);
      wait_quiet();
      send(16'h1234, 8'd7, 8'h20, 0, 8'h02, 8'h01, -1);
      wait_quiet();
      send(16'hFFFE, 8'd4, 8'hFF, 2, 8'h03, 8'h01, -1);
      wait_quiet();

      // Line 2 of 4 never completes; next command must clear seq_err
      send(16'h0400, 8'd16, 8'h40, 4, 8'h01, 8'h00, 1);
      wait_quiet();
      send(16'h0800, 8'd1, 8'h50, 1, 8'h05, 8'h01, -1);
      wait_quiet();

      // Spurious fetch_done while idle
      spur_cyc = cyc + 1;
      repeat (2) @(negedge clk);
      chk("spurious_done_lines_done", int'(bus.lines_done), last_lines);
      chk("spurious_done_seq_busy", int'(bus.seq_busy), 0);

      // cmd_valid held through the whole first command
      c = cyc;
      drive_cmd(16'h2000, 8'd3, 8'h30, 2, 8'h07, 8'h00);
      push_expect(c, 16'h2000, 8'd3, 8'h30, 2, 8'h07, 8'h00, -1);
      @(negedge clk);
      drive_cmd(16'h3000, 8'd5, 8'h60, 1, 8'h08, 8'h01);
      c2 = -1;
      for (int k = 0; k < 60 && c2 < 0; k++) begin
         @(negedge clk);
         if (bus.cmd_ready) c2 = cyc;
      end
      chk("held_valid_second_accept_cycle", c2, c + 4 * 2 + 2);
      if (c2 >= 0) push_expect(c2, 16'h3000, 8'd5, 8'h60, 1, 8'h08, 8'h01, -1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_quiet();

      // Reset while waiting on line 0 of a 3-line command
      send(16'h5000, 8'd8, 8'h70, 3, 8'h01, 8'h01, -1);
      @(negedge clk);
      rst    = 1'b1;
      in_rst = 1'b1;
      exp_en.delete();
      exp_dn.delete();
      drop_cyc = -1;
      @(negedge clk);
      rst    = 1'b0;
      in_rst = 1'b0;
      chk("mid_rst_cmd_ready", int'(bus.cmd_ready), 1);
      chk("mid_rst_fetch_enable", int'(bus.fetch_enable), 0);
      chk("mid_rst_seq_busy", int'(bus.seq_busy), 0);
      chk("mid_rst_no_seq_done", int'(bus.seq_done), 0);
      repeat (3) @(negedge clk);
      chk("post_rst_lines_done", int'(bus.lines_done), 0);
      send(16'h6000, 8'd2, 8'h80, 3, 8'h02, 8'h00, -1);
      wait_quiet();

      // Randomized commands
      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         s    = 16'($urandom);
         st   = 8'($urandom);
         d    = 8'($urandom);
         t    = 8'($urandom);
         m    = 8'($urandom_range(0, 1));
         len  = int'($urandom_range(0, 5));
         drop = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         send(s, st, d, len, t, m, drop);
         wait_quiet();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors",
               n_checks, n_errs);
      $fatal(1, "global timeout");
   end

endmodule
